// File: rtl/breakout_pkg.sv
// Shared types, banner codes and defaults for the Breakout game controller.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_NEWGAME,
    ST_PLAY,
    ST_NEWBALL,
    ST_OVER,
    ST_WIN
  } state_t;

  localparam logic [1:0] TXT_NONE  = 2'd0;
  localparam logic [1:0] TXT_PRESS = 2'd1;
  localparam logic [1:0] TXT_OVER  = 2'd2;
  localparam logic [1:0] TXT_WIN   = 2'd3;

  localparam int DEF_LIVES          = 3;
  localparam int DEF_TIMEOUT_FRAMES = 120;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/breakout_frame_timer.sv
// Frame-count delay timer: loads on timed-state entry, counts frame ticks down.
module breakout_frame_timer
  import breakout_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic frame_tick,
  output logic done
);

  localparam int CW = $clog2(TIMEOUT_FRAMES + 1);

  logic [CW-1:0] count;

  // Load takes priority so a tick on the load edge is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(TIMEOUT_FRAMES);
    end else if (frame_tick && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game-state controller: lives, delays, pause/restart and banners.
// Optional BCD win counter enabled by defining BREAKOUT_SCORE_EN.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int LIVES          = DEF_LIVES,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] key,
  input  logic       miss,
  input  logic       won,
  output logic       pause,
  output logic       restart,
  output logic [1:0] lives,
  output logic [1:0] text_sel
`ifdef BREAKOUT_SCORE_EN
  ,
  output logic [7:0] win_count
`endif
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t     state, next_state;
  logic       key_pressed;
  logic       load;
  logic       done;
  logic       pause_d, restart_d;
  logic [1:0] text_d;

  assign key_pressed = (key != 2'b11);

  breakout_frame_timer #(
    .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .frame_tick(frame_tick),
    .done      (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_NEWGAME;
      restart  <= 1'b1;
      pause    <= 1'b0;
      text_sel <= TXT_PRESS;
    end else begin
      state    <= next_state;
      restart  <= restart_d;
      pause    <= pause_d;
      text_sel <= text_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_NEWGAME: if (key_pressed) next_state = ST_PLAY;
      ST_PLAY: begin
        if (miss) begin
          next_state = (lives > 2'd1) ? ST_NEWBALL : ST_OVER;
        end else if (won) begin
          next_state = ST_WIN;
        end
      end
      ST_NEWBALL: if (done && key_pressed) next_state = ST_PLAY;
      ST_OVER:    if (done) next_state = ST_NEWGAME;
      ST_WIN:     if (done) next_state = ST_NEWGAME;
      default:    next_state = ST_NEWGAME;
    endcase
  end

  // Every exit from PLAY enters a timed state.
  assign load = (state == ST_PLAY) && (next_state != ST_PLAY);

  // Outputs decoded from next_state so they move with the state register.
  always_comb begin
    restart_d = 1'b1;
    pause_d   = 1'b0;
    text_d    = TXT_PRESS;
    unique case (next_state)
      ST_NEWGAME: text_d = TXT_PRESS;
      ST_PLAY: begin
        restart_d = 1'b0;
        text_d    = TXT_NONE;
      end
      ST_NEWBALL: begin
        restart_d = 1'b0;
        pause_d   = 1'b1;
      end
      ST_OVER: text_d = TXT_OVER;
      ST_WIN:  text_d = TXT_WIN;
      default: text_d = TXT_PRESS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lives <= LIVES_INIT;
    end else if (state == ST_NEWGAME && next_state == ST_PLAY) begin
      lives <= LIVES_INIT;
    end else if (state == ST_PLAY && miss) begin
      lives <= lives - 2'd1;
    end
  end

`ifdef BREAKOUT_SCORE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count <= 8'h00;
    end else if (state == ST_PLAY && won && !miss) begin
      win_count <= bcd_inc(win_count);
    end
  end
`endif

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed self-checking bench for breakout_game_ctrl (default parameters).
// Win-counter checks are compiled in when BREAKOUT_SCORE_EN is defined.
module tb_breakout_game_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic [1:0] key;
  logic       miss;
  logic       won;
  logic       pause;
  logic       restart;
  logic [1:0] lives;
  logic [1:0] text_sel;
`ifdef BREAKOUT_SCORE_EN
  logic [7:0] win_count;
`endif

  int n_cmp;
  int n_err;

  breakout_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .key       (key),
    .miss      (miss),
    .won       (won),
    .pause     (pause),
    .restart   (restart),
    .lives     (lives),
    .text_sel  (text_sel)
`ifdef BREAKOUT_SCORE_EN
    ,
    .win_count (win_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic press;
    key = 2'b10;
    cyc(1);
    key = 2'b11;
  endtask

  task automatic pulse_miss;
    miss = 1'b1;
    cyc(1);
    miss = 1'b0;
  endtask

  task automatic pulse_won;
    won = 1'b1;
    cyc(1);
    won = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    n_cmp++;
    if (restart !== 1'b1) begin
      n_err++; $display("FAIL reset_restart got %b exp 1", restart);
    end
    n_cmp++;
    if (pause !== 1'b0) begin
      n_err++; $display("FAIL reset_pause got %b exp 0", pause);
    end
    n_cmp++;
    if (text_sel !== 2'd1) begin
      n_err++; $display("FAIL reset_text got %0d exp 1", text_sel);
    end
    n_cmp++;
    if (lives !== 2'd3) begin
      n_err++; $display("FAIL reset_lives got %0d exp 3", lives);
    end
`ifdef BREAKOUT_SCORE_EN
    n_cmp++;
    if (win_count !== 8'h00) begin
      n_err++; $display("FAIL reset_wins got %h exp 00", win_count);
    end
`endif
  endtask

  task automatic test_start;
    press;
    n_cmp++;
    if (restart !== 1'b0 || text_sel !== 2'd0 || pause !== 1'b0) begin
      n_err++;
      $display("FAIL start_play got r%b p%b t%0d exp r0 p0 t0",
               restart, pause, text_sel);
    end
    n_cmp++;
    if (lives !== 2'd3) begin
      n_err++; $display("FAIL start_lives got %0d exp 3", lives);
    end
  endtask

  task automatic test_newball;
    pulse_miss;
    n_cmp++;
    if (pause !== 1'b1 || text_sel !== 2'd1 || restart !== 1'b0) begin
      n_err++;
      $display("FAIL nb_enter got r%b p%b t%0d exp r0 p1 t1",
               restart, pause, text_sel);
    end
    n_cmp++;
    if (lives !== 2'd2) begin
      n_err++; $display("FAIL nb_lives got %0d exp 2", lives);
    end
    key = 2'b01;
    ticks(119);
    n_cmp++;
    if (pause !== 1'b1) begin
      n_err++; $display("FAIL nb_119 got pause %b exp 1", pause);
    end
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    n_cmp++;
    if (pause !== 1'b1) begin
      n_err++; $display("FAIL nb_120_edge got pause %b exp 1", pause);
    end
    cyc(1);
    key = 2'b11;
    n_cmp++;
    if (pause !== 1'b0 || text_sel !== 2'd0) begin
      n_err++;
      $display("FAIL nb_exit got p%b t%0d exp p0 t0", pause, text_sel);
    end
  endtask

  task automatic test_over;
    pulse_miss;
    ticks(120);
    press;
    n_cmp++;
    if (lives !== 2'd1 || text_sel !== 2'd0) begin
      n_err++;
      $display("FAIL ov_pre got l%0d t%0d exp l1 t0", lives, text_sel);
    end
    miss = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    miss = 1'b0;
    frame_tick = 1'b0;
    n_cmp++;
    if (lives !== 2'd0 || text_sel !== 2'd2 || restart !== 1'b1
        || pause !== 1'b0) begin
      n_err++;
      $display("FAIL ov_enter got l%0d t%0d r%b p%b exp l0 t2 r1 p0",
               lives, text_sel, restart, pause);
    end
    pulse_miss;
    n_cmp++;
    if (lives !== 2'd0 || text_sel !== 2'd2) begin
      n_err++;
      $display("FAIL ov_miss_ign got l%0d t%0d exp l0 t2", lives, text_sel);
    end
    ticks(119);
    n_cmp++;
    if (text_sel !== 2'd2) begin
      n_err++; $display("FAIL ov_hold got t%0d exp 2", text_sel);
    end
    ticks(1);
    n_cmp++;
    if (text_sel !== 2'd1 || restart !== 1'b1 || lives !== 2'd0) begin
      n_err++;
      $display("FAIL ov_exit got t%0d r%b l%0d exp t1 r1 l0",
               text_sel, restart, lives);
    end
    press;
    n_cmp++;
    if (lives !== 2'd3 || text_sel !== 2'd0) begin
      n_err++;
      $display("FAIL ov_reload got l%0d t%0d exp l3 t0", lives, text_sel);
    end
  endtask

  task automatic test_miss_won;
    miss = 1'b1;
    won = 1'b1;
    cyc(1);
    miss = 1'b0;
    won = 1'b0;
    n_cmp++;
    if (pause !== 1'b1 || text_sel !== 2'd1 || lives !== 2'd2) begin
      n_err++;
      $display("FAIL mw_enter got p%b t%0d l%0d exp p1 t1 l2",
               pause, text_sel, lives);
    end
`ifdef BREAKOUT_SCORE_EN
    n_cmp++;
    if (win_count !== 8'h00) begin
      n_err++; $display("FAIL mw_wins got %h exp 00", win_count);
    end
`endif
    ticks(120);
    press;
    n_cmp++;
    if (pause !== 1'b0 || text_sel !== 2'd0) begin
      n_err++;
      $display("FAIL mw_resume got p%b t%0d exp p0 t0", pause, text_sel);
    end
  endtask

  task automatic test_win;
    logic [1:0] exp_lives;
    exp_lives = 2'd2;
`ifdef BREAKOUT_SCORE_EN
    for (int i = 0; i < 99; i++) begin
      pulse_won;
      ticks(120);
      press;
    end
    exp_lives = 2'd3;
    n_cmp++;
    if (win_count !== 8'h99) begin
      n_err++; $display("FAIL win_preload got %h exp 99", win_count);
    end
`endif
    pulse_won;
    n_cmp++;
    if (text_sel !== 2'd3 || restart !== 1'b1 || pause !== 1'b0) begin
      n_err++;
      $display("FAIL win_enter got t%0d r%b p%b exp t3 r1 p0",
               text_sel, restart, pause);
    end
`ifdef BREAKOUT_SCORE_EN
    n_cmp++;
    if (win_count !== 8'h00) begin
      n_err++; $display("FAIL win_wrap got %h exp 00", win_count);
    end
`endif
    pulse_miss;
    pulse_won;
    n_cmp++;
    if (text_sel !== 2'd3 || lives !== exp_lives) begin
      n_err++;
      $display("FAIL win_ignore got t%0d l%0d exp t3 l%0d",
               text_sel, lives, exp_lives);
    end
`ifdef BREAKOUT_SCORE_EN
    n_cmp++;
    if (win_count !== 8'h00) begin
      n_err++; $display("FAIL win_ign_cnt got %h exp 00", win_count);
    end
`endif
    ticks(120);
    n_cmp++;
    if (text_sel !== 2'd1 || restart !== 1'b1) begin
      n_err++;
      $display("FAIL win_exit got t%0d r%b exp t1 r1", text_sel, restart);
    end
    press;
  endtask

  task automatic test_async_reset;
    pulse_miss;
    ticks(70);
    n_cmp++;
    if (pause !== 1'b1 || lives !== 2'd2) begin
      n_err++;
      $display("FAIL ar_pre got p%b l%0d exp p1 l2", pause, lives);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (restart !== 1'b1 || pause !== 1'b0 || text_sel !== 2'd1
        || lives !== 2'd3) begin
      n_err++;
      $display("FAIL ar_async got r%b p%b t%0d l%0d exp r1 p0 t1 l3",
               restart, pause, text_sel, lives);
    end
    cyc(2);
    rst = 1'b0;
    cyc(3);
    n_cmp++;
    if (text_sel !== 2'd1 || restart !== 1'b1) begin
      n_err++;
      $display("FAIL ar_after got t%0d r%b exp t1 r1", text_sel, restart);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    frame_tick = 1'b0;
    key = 2'b11;
    miss = 1'b0;
    won = 1'b0;
    test_reset;
    test_start;
    test_newball;
    test_over;
    test_miss_won;
    test_win;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
